// File: rtl/rs_scheduler.sv
// -----------------------------------------------------------------------------
// rs_scheduler
//
// Allocation and issue scheduler for a reservation station of NUM_ENTRIES
// entries. Allocation picks the lowest-index free entry; issue picks the
// oldest entry that is both busy and ready, using an age matrix that records
// allocation order.
//
// Ports
//   clock           single clock, rising edge
//   reset           synchronous, active-low
//   dispatch_valid  dispatch presents an instruction for allocation
//   entry_busy      per-entry busy flags (entry holds an instruction)
//   entry_ready     per-entry ready flags (both operands available)
//   fu_ready        execute stage accepts one instruction this cycle
//   squash          mispredict flush: clears all busy entries, zeroes ages
//   wr_en           one-hot (or zero) write enable to the allocated entry
//   clear           per-entry clear (issued entry, or all busy on squash)
//   issue_valid     an issue candidate exists
//   issue_idx       index of the issue candidate (0 when none)
//   rs_full         no free entry; dispatch must stall
//
// Issue handshake: issue_valid/issue_idx are offered combinationally; an
// issue happens in any cycle where issue_valid=1 and fu_ready=1, and in that
// cycle clear[issue_idx] is asserted. With fu_ready=0 nothing is cleared and
// the selection is simply recomputed next cycle, so an older entry that
// becomes ready may displace the current candidate.
// -----------------------------------------------------------------------------
module rs_scheduler #(
    parameter int NUM_ENTRIES = 8
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           dispatch_valid,
    input  logic [NUM_ENTRIES-1:0]         entry_busy,
    input  logic [NUM_ENTRIES-1:0]         entry_ready,
    input  logic                           fu_ready,
    input  logic                           squash,
    output logic [NUM_ENTRIES-1:0]         wr_en,
    output logic [NUM_ENTRIES-1:0]         clear,
    output logic                           issue_valid,
    output logic [$clog2(NUM_ENTRIES)-1:0] issue_idx,
    output logic                           rs_full
);

    localparam int IDX_W = $clog2(NUM_ENTRIES);

    // older[i][j] = 1: entry i was allocated before entry j. Diagonal stays 0.
    logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0] older;

    logic [NUM_ENTRIES-1:0] free_vec;
    logic [NUM_ENTRIES-1:0] cand;
    logic [NUM_ENTRIES-1:0] oldest;
    logic [NUM_ENTRIES-1:0] col;
    logic [IDX_W-1:0]       alloc_idx;
    logic [IDX_W-1:0]       sel_idx;
    logic                   alloc_ok;

    // Lowest set bit of a vector (0 if the vector is empty).
    function automatic logic [IDX_W-1:0] first_set(input logic [NUM_ENTRIES-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (v[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

    // An entry being issued this cycle is still busy, so it is never free here.
    assign free_vec  = ~entry_busy;
    assign rs_full   = (free_vec == '0);
    assign alloc_idx = first_set(free_vec);
    assign alloc_ok  = reset && dispatch_valid && !rs_full && !squash;

    assign cand = entry_busy & entry_ready;

    // A candidate is "oldest" when no other candidate is marked older than it.
    always_comb begin
        col    = '0;
        oldest = '0;
        for (int c = 0; c < NUM_ENTRIES; c++) begin
            col = '0;
            for (int j = 0; j < NUM_ENTRIES; j++) begin
                col[j] = older[j][c];
            end
            oldest[c] = cand[c] && ((col & cand) == '0);
        end
    end

    // If the matrix holds a cycle among candidates (cannot arise from the
    // update rule, but guard anyway), fall back to the lowest-index candidate.
    assign sel_idx = (oldest != '0) ? first_set(oldest) : first_set(cand);

    always_comb begin
        wr_en       = '0;
        clear       = '0;
        issue_valid = 1'b0;
        issue_idx   = '0;
        if (reset) begin
            if (squash) begin
                clear = entry_busy;
            end else begin
                if (alloc_ok) begin
                    wr_en[alloc_idx] = 1'b1;
                end
                if (cand != '0) begin
                    issue_valid = 1'b1;
                    issue_idx   = sel_idx;
                    if (fu_ready) begin
                        clear[sel_idx] = 1'b1;
                    end
                end
            end
        end
    end

    // Allocation of entry k makes k the youngest: nobody is younger than k
    // (row k cleared) and everyone else is older than k (column k set).
    always_ff @(posedge clock) begin
        if (!reset || squash) begin
            older <= '0;
        end else if (alloc_ok) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                older[alloc_idx][i] <= 1'b0;
                if (IDX_W'(i) != alloc_idx) begin
                    older[i][alloc_idx] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/rs_scheduler.md
RS_SCHEDULER -- requirements
Module: rs_scheduler

Interface
REQ-001 The module SHALL have parameter NUM_ENTRIES, default 8, giving the number of RS entries managed; legal values are powers of two from 2 to 16.
REQ-002 The module SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: synchronous, active-low reset, asserted when 0 and sampled on the rising edge of clock.
REQ-004 The module SHALL have port dispatch_valid, input, 1 bit: the dispatch stage presents an instruction for RS allocation this cycle.
REQ-005 The module SHALL have port entry_busy, input, NUM_ENTRIES bits: per-entry busy flags from the RS entries.
REQ-006 The module SHALL have port entry_ready, input, NUM_ENTRIES bits: per-entry ready flags, meaning both operands are available.
REQ-007 The module SHALL have port fu_ready, input, 1 bit: the execute stage accepts one issued instruction this cycle.
REQ-008 The module SHALL have port squash, input, 1 bit: branch mispredict flush.
REQ-009 The module SHALL have port wr_en, output, NUM_ENTRIES bits: one-hot or zero write enable to the RS entries.
REQ-010 The module SHALL have port clear, output, NUM_ENTRIES bits: per-entry clear.
REQ-011 The module SHALL have port issue_valid, output, 1 bit: an issue candidate exists.
REQ-012 The module SHALL have port issue_idx, output, $clog2(NUM_ENTRIES) bits: index of the issue candidate.
REQ-013 The module SHALL have port rs_full, output, 1 bit: no free entry; dispatch must stall.

Function
REQ-014 A free entry SHALL be one with entry_busy=0; rs_full SHALL be 1 exactly when no entry is free.
REQ-015 Allocation:
- When dispatch_valid=1, rs_full=0 and squash=0, wr_en SHALL be one-hot on the lowest-index free entry, combinationally in the same cycle.
- Otherwise wr_en SHALL be 0.
REQ-016 The scheduler SHALL hold an NUM_ENTRIES x NUM_ENTRIES age matrix, older[i][j], where 1 means entry i was allocated before entry j; the diagonal SHALL always read 0.
REQ-017 On a rising edge with wr_en[k]=1, the matrix SHALL update as follows:
- Row k is set to all 0.
- Column k is set to 1 for every i != k.
- All other bits are unchanged.
REQ-018 A candidate SHALL be an entry with entry_busy=1 and entry_ready=1.
REQ-019 Issue selection:
- issue_valid SHALL be 1 when any candidate exists and squash=0.
- issue_idx SHALL name the candidate c for which no other candidate j has older[j][c]=1.
- If older bits are inconsistent (e.g. entries never allocated through this block after reset), the lowest-index such candidate SHALL be chosen.
- When issue_valid=0, issue_idx SHALL be 0.
REQ-020 Issue handshake:
- An issue SHALL occur in a cycle where issue_valid=1 and fu_ready=1.
- In that cycle clear[issue_idx] SHALL be 1, combinationally, and all other clear bits SHALL be 0 (absent squash).
- With fu_ready=0 the candidate SHALL be held, no clear SHALL be asserted, and selection SHALL be re-evaluated next cycle (a newly ready older entry may displace it).
REQ-021 Simultaneous issue and allocation:
- An entry being cleared this cycle is still busy, so it SHALL NOT be allocated in the same cycle.
- Allocation of another entry and issue SHALL proceed in the same cycle.
- An entry written this cycle SHALL NOT be an issue candidate until its entry_busy/entry_ready reflect the write.
REQ-022 Squash:
- clear SHALL equal entry_busy.
- wr_en, issue_valid and issue_idx SHALL be 0.
- On the edge, the age matrix SHALL be zeroed.
- Squash SHALL override dispatch and issue.
REQ-023 All outputs except the age matrix SHALL be combinational functions of the inputs and the age matrix; latency from entry_ready rising to issue_valid SHALL be 0 cycles.
REQ-024 At most one issue and one allocation SHALL occur per cycle.

Reset
REQ-025 While reset=0, the outputs SHALL be held as follows:
- wr_en=0, clear=0.
- issue_valid=0, issue_idx=0.
- rs_full SHALL still reflect entry_busy.
REQ-026 A rising edge with reset=0 SHALL zero the age matrix, including when reset is asserted mid-operation with entries busy.
REQ-027 The first cycle after reset deasserts SHALL behave as an empty scheduler if entry_busy=0.

Verification
REQ-028 Scenario, empty allocation:
- Stimulus: entry_busy=0, dispatch_valid=1.
- Required response: wr_en=8'b00000001, rs_full=0.
- Stimulus: entry_busy=8'b00000111.
- Required response: wr_en=8'b00001000.
REQ-029 Scenario, full stall:
- Stimulus: entry_busy=8'hFF, dispatch_valid=1.
- Required response: rs_full=1, wr_en=0.
REQ-030 Scenario, oldest-first issue:
- Stimulus: allocate entries 2, 0, 5 in that order; then entry_ready=8'b00100101, fu_ready=1.
- Required response: issue_idx=2, clear=8'b00000100.
- Stimulus: after entry 2 is freed.
- Required response: issue_idx=0.
REQ-031 Scenario, issue stall:
- Stimulus: one candidate at entry 3, fu_ready=0 for 3 cycles.
- Required response: issue_valid=1, issue_idx=3, clear=0 in each of those cycles.
- Stimulus: fu_ready=1.
- Required response: clear=8'b00001000.
REQ-032 Scenario, simultaneous issue and allocation:
- Stimulus: entry_busy=8'b00000001, entry_ready=8'b00000001, fu_ready=1, dispatch_valid=1.
- Required response: clear=8'b00000001, wr_en=8'b00000010.
REQ-033 Scenario, squash and reset:
- Stimulus: squash=1 with entry_busy=8'b10110000.
- Required response: clear=8'b10110000, wr_en=0, issue_valid=0.
- Stimulus: reset=0 mid-operation.
- Required response: all outputs except rs_full are 0; after release, allocation order restarts at the lowest free index with a cleared age matrix.
